// File: rtl/oled_spi_sink_if.sv
// SPI write port of an SSD1331-style OLED controller plus the decoded
// command/pixel stream it produces.
`timescale 1ns/1ps

interface oled_spi_sink_if;
  logic        cs;
  logic        sdin;
  logic        sclk;
  logic        d_cn;
  logic        cmd_valid;
  logic [7:0]  cmd_byte;
  logic        pixel_valid;
  logic [15:0] pixel_data;
  logic [6:0]  pixel_x;
  logic [5:0]  pixel_y;
  logic        frame_done;

  modport master (
    output cs, sdin, sclk, d_cn,
    input  cmd_valid, cmd_byte, pixel_valid, pixel_data, pixel_x, pixel_y, frame_done
  );

  modport slave (
    input  cs, sdin, sclk, d_cn,
    output cmd_valid, cmd_byte, pixel_valid, pixel_data, pixel_x, pixel_y, frame_done
  );
endinterface

// File: rtl/oled_spi_sink.sv
// SPI sink for an OLED controller: deserialises bytes, consumes column/row
// window commands and turns RGB565 data byte pairs into addressed pixels.
`timescale 1ns/1ps

module oled_spi_sink #(
  parameter int COLS = 96,
  parameter int ROWS = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  oled_spi_sink_if.slave  spi
);

  localparam logic [7:0] COL_MAX = 8'(COLS - 1);
  localparam logic [7:0] ROW_MAX = 8'(ROWS - 1);

  typedef enum logic [2:0] {IDLE, COL_S, COL_E, ROW_S, ROW_E} dec_state_t;

  function automatic logic [6:0] clamp_col(input logic [7:0] b);
    return (b > COL_MAX) ? COL_MAX[6:0] : b[6:0];
  endfunction

  function automatic logic [5:0] clamp_row(input logic [7:0] b);
    return (b > ROW_MAX) ? ROW_MAX[5:0] : b[5:0];
  endfunction

  // Stage [2] of each chain is the aligned copy used with the registered edge.
  logic [2:0] cs_sync, sdin_sync, sclk_sync, dcn_sync;
  logic       sclk_rise;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchronizer chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_sync   <= '0;
      sdin_sync <= '0;
      sclk_sync <= '0;
      dcn_sync  <= '0;
      sclk_rise <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[1:0],   spi.cs};
      sdin_sync <= {sdin_sync[1:0], spi.sdin};
      sclk_sync <= {sclk_sync[1:0], spi.sclk};
      dcn_sync  <= {dcn_sync[1:0],  spi.d_cn};
      sclk_rise <= sclk_sync[1] & ~sclk_sync[2];
    end
  end

  logic [6:0] shreg;
  logic [2:0] bit_cnt;
  logic       phase_lo;
  logic [7:0] hi_byte;
  dec_state_t state;
  logic [6:0] col_start, col_end, cur_x;
  logic [5:0] row_start, row_end, cur_y;

  logic [7:0] byte_v;
  logic [6:0] col_param, col_end_v;
  logic [5:0] row_param, row_end_v;

  // NOTE: every always_comb output is assigned on every path, so no latches.
  always_comb begin
    byte_v    = {shreg, sdin_sync[2]};
    col_param = clamp_col(byte_v);
    row_param = clamp_row(byte_v);
    col_end_v = (col_param < col_start) ? col_start : col_param;
    row_end_v = (row_param < row_start) ? row_start : row_param;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg           <= '0;
      bit_cnt         <= '0;
      phase_lo        <= 1'b0;
      hi_byte         <= '0;
      state           <= IDLE;
      col_start       <= '0;
      col_end         <= COL_MAX[6:0];
      row_start       <= '0;
      row_end         <= ROW_MAX[5:0];
      cur_x           <= '0;
      cur_y           <= '0;
      spi.cmd_valid   <= 1'b0;
      spi.cmd_byte    <= '0;
      spi.pixel_valid <= 1'b0;
      spi.pixel_data  <= '0;
      spi.pixel_x     <= '0;
      spi.pixel_y     <= '0;
      spi.frame_done  <= 1'b0;
    end else begin
      spi.cmd_valid   <= 1'b0;
      spi.pixel_valid <= 1'b0;
      spi.frame_done  <= 1'b0;
      if (cs_sync[2]) begin
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        shreg   <= byte_v[6:0];
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          if (!dcn_sync[2]) begin
            phase_lo <= 1'b0;
            unique case (state)
              IDLE: begin
                if (byte_v == 8'h15)      state <= COL_S;
                else if (byte_v == 8'h75) state <= ROW_S;
                else begin
                  spi.cmd_valid <= 1'b1;
                  spi.cmd_byte  <= byte_v;
                end
              end
              COL_S: begin
                col_start <= col_param;
                state     <= COL_E;
              end
              COL_E: begin
                col_end <= col_end_v;
                cur_x   <= col_start;
                state   <= IDLE;
              end
              ROW_S: begin
                row_start <= row_param;
                state     <= ROW_E;
              end
              ROW_E: begin
                row_end <= row_end_v;
                cur_y   <= row_start;
                state   <= IDLE;
              end
              default: state <= IDLE;
            endcase
          end else begin
            // Data aborts any half-written window command.
            state <= IDLE;
            if (!phase_lo) begin
              hi_byte  <= byte_v;
              phase_lo <= 1'b1;
            end else begin
              phase_lo        <= 1'b0;
              spi.pixel_valid <= 1'b1;
              spi.pixel_data  <= {hi_byte, byte_v};
              spi.pixel_x     <= cur_x;
              spi.pixel_y     <= cur_y;
              if (cur_x < col_end) begin
                cur_x <= cur_x + 7'd1;
              end else begin
                cur_x <= col_start;
                if (cur_y < row_end) begin
                  cur_y <= cur_y + 6'd1;
                end else begin
                  cur_y          <= row_start;
                  spi.frame_done <= 1'b1;
                end
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_oled_spi_sink.sv
// Directed bench for oled_spi_sink: SPI bytes in, decoded pixels and
// commands captured at negedge clk and checked against hand-computed values.
`timescale 1ns/1ps

module tb_oled_spi_sink;

  logic clk = 1'b0;
  logic reset_n;

  oled_spi_sink_if bus();

  oled_spi_sink #(.COLS(96), .ROWS(64)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .spi     (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic [6:0]  x;
    logic [5:0]  y;
    logic        fd;
  } pix_t;

  pix_t       pix_q[$];
  logic [7:0] cmd_q[$];
  int         collisions = 0;
  int         n_checks   = 0;
  int         n_fail     = 0;

  always @(negedge clk) begin
    if (bus.pixel_valid)
      pix_q.push_back({bus.pixel_data, bus.pixel_x, bus.pixel_y, bus.frame_done});
    if (bus.cmd_valid)
      cmd_q.push_back(bus.cmd_byte);
    if ((bus.pixel_valid && bus.cmd_valid) || (bus.frame_done && !bus.pixel_valid))
      collisions++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // SPI mode 0: data set while sclk low, 4 clk per phase.
  task automatic send_bits(input logic [7:0] b, input int n, input logic dc);
    for (int i = 0; i < n; i++) begin
      bus.sdin = b[7-i];
      bus.d_cn = dc;
      bus.sclk = 1'b0;
      #40;
      bus.sclk = 1'b1;
      #40;
    end
    bus.sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc);
    send_bits(b, 8, dc);
  endtask

  task automatic send_pix(input logic [15:0] d);
    send_byte(d[15:8], 1'b1);
    send_byte(d[7:0], 1'b1);
  endtask

  task automatic pop_pix(input string tag, input logic [15:0] d, input int x, input int y,
                         input logic fd);
    pix_t p;
    for (int k = 0; k < 20 && pix_q.size() == 0; k++) @(negedge clk);
    check({tag, " present"}, pix_q.size() > 0, 1);
    if (pix_q.size() > 0) begin
      p = pix_q.pop_front();
      check({tag, " data"}, p.data, d);
      check({tag, " x"}, p.x, x);
      check({tag, " y"}, p.y, y);
      check({tag, " frame_done"}, p.fd, fd);
    end
  endtask

  task automatic pop_cmd(input string tag, input logic [7:0] c);
    for (int k = 0; k < 20 && cmd_q.size() == 0; k++) @(negedge clk);
    check({tag, " present"}, cmd_q.size() > 0, 1);
    if (cmd_q.size() > 0) check({tag, " byte"}, cmd_q.pop_front(), c);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n  = 1'b0;
    bus.cs   = 1'b1;
    bus.sclk = 1'b0;
    bus.sdin = 1'b0;
    bus.d_cn = 1'b0;
    #23;
    check("rst pixel_valid", bus.pixel_valid, 0);
    check("rst cmd_valid", bus.cmd_valid, 0);
    check("rst pixel_data", bus.pixel_data, 0);
    check("rst cmd_byte", bus.cmd_byte, 0);
    #7;
    reset_n = 1'b1;
    #40;
    bus.cs = 1'b0;
    #40;

    // First pixel F800 at (0,0), valid exactly 4 clk after the 16th rise.
    send_byte(8'hF8, 1'b1);
    send_bits(8'h00, 7, 1'b1);
    bus.sdin = 1'b0;
    bus.sclk = 1'b0;
    #40;
    bus.sclk = 1'b1;
    #30;
    check("latency 3clk", bus.pixel_valid, 0);
    #10;
    check("latency 4clk", bus.pixel_valid, 1);
    #10;
    check("pulse width", bus.pixel_valid, 0);
    bus.sclk = 1'b0;
    pop_pix("first", 16'hF800, 0, 0, 1'b0);

    // Window cols 10..20, rows 5..6: 22 pixels wrap to a frame, one more restarts.
    send_byte(8'h15, 1'b0);
    send_byte(8'h0A, 1'b0);
    send_byte(8'h14, 1'b0);
    send_byte(8'h75, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h06, 1'b0);
    for (int i = 0; i < 23; i++) begin
      send_pix({8'(i), 8'h5A});
      pop_pix($sformatf("win%0d", i), {8'(i), 8'h5A}, 10 + (i % 11), 5 + ((i / 11) % 2),
              i == 21);
    end
    check("window no cmd", cmd_q.size(), 0);

    // Pass-through command, then clamped/corrected column window 95..95.
    send_byte(8'hAF, 1'b0);
    pop_cmd("cmd AF", 8'hAF);
    #40;
    check("cmd_byte held", bus.cmd_byte, 8'hAF);
    send_byte(8'h15, 1'b0);
    send_byte(8'h70, 1'b0);
    send_byte(8'h02, 1'b0);
    send_pix(16'h1234);
    pop_pix("clamp0", 16'h1234, 95, 5, 1'b0);
    send_pix(16'h5678);
    pop_pix("clamp1", 16'h5678, 95, 6, 1'b1);

    // cs high mid-byte discards the partial byte.
    send_bits(8'hFF, 5, 1'b1);
    bus.cs = 1'b1;
    #100;
    bus.cs = 1'b0;
    #40;
    send_pix(16'h07E0);
    pop_pix("cs abort", 16'h07E0, 95, 5, 1'b0);
    check("cs abort extra", pix_q.size(), 0);

    // A command drops the unpaired high byte.
    send_byte(8'hF8, 1'b1);
    send_byte(8'hA0, 1'b0);
    send_pix(16'h07E0);
    pop_cmd("cmd A0", 8'hA0);
    pop_pix("phase reset", 16'h07E0, 95, 6, 1'b1);

    // Data after 0x15 aborts the window command; the next command passes through.
    send_byte(8'h15, 1'b0);
    send_pix(16'h1234);
    pop_pix("fsm abort", 16'h1234, 95, 5, 1'b0);
    send_byte(8'h0B, 1'b0);
    pop_cmd("cmd after abort", 8'h0B);

    // Reset 12 bits into a pixel clears outputs at once and restores the window.
    send_byte(8'hAA, 1'b1);
    send_bits(8'hBB, 4, 1'b1);
    #20;
    reset_n = 1'b0;
    #3;
    check("async pixel_data", bus.pixel_data, 0);
    check("async pixel_x", bus.pixel_x, 0);
    check("async pixel_y", bus.pixel_y, 0);
    check("async cmd_byte", bus.cmd_byte, 0);
    #17;
    bus.cs   = 1'b1;
    bus.sclk = 1'b0;
    #40;
    reset_n = 1'b1;
    #40;
    bus.cs = 1'b0;
    #40;
    send_pix(16'h001F);
    pop_pix("post reset", 16'h001F, 0, 0, 1'b0);
    for (int k = 1; k < 96; k++) begin
      send_pix(16'(k));
      pop_pix($sformatf("row0 x%0d", k), 16'(k), k, 0, 1'b0);
    end
    send_pix(16'hBEEF);
    pop_pix("row1 wrap", 16'hBEEF, 0, 1, 1'b0);

    check("no collisions", collisions, 0);
    check("no stray cmds", cmd_q.size(), 0);
    check("no stray pixels", pix_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
